enable_synchronizer: RTL and testbench

- Brings an asynchronous enable level into the `clk` domain (32 MHz nominal, 31.25 ns period).
- Rejects glitches shorter than a programmable number of cycles.
- Presents a clean registered level plus one-cycle rise/fall strobes.
- Sits at the boundary between an external/foreign-domain enable source and synchronous control logic.

---
 rtl/enable_sync_pkg.sv | 13 +
 rtl/sync_cell.sv | 28 ++
 rtl/enable_synchronizer.sv | 71 +++++++
 tb/tb_enable_synchronizer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/enable_sync_pkg.sv
// Shared defaults and helpers for the enable synchroniser and its CDC cells.
`timescale 1ns/1ps
package enable_sync_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILTER_LEN  = 4;

  // Filter counter width: enough to hold FILTER_LEN-1, never narrower than one bit.
  function automatic int cnt_width(input int filter_len);
    return (filter_len <= 2) ? 1 : $clog2(filter_len);
  endfunction

endpackage

// File: rtl/sync_cell.sv
// N-flop single-bit synchroniser with synchronous active-low reset.
// Generic CDC cell; the stages carry no logic between them.
`timescale 1ns/1ps
module sync_cell
  import enable_sync_pkg::*;
#(
  parameter int N_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [N_STAGES-1:0] r_sync;

  // Shift the asynchronous bit through the metastability chain.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[N_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[N_STAGES-1];

endmodule

// File: rtl/enable_synchronizer.sv
// Synchronises an asynchronous enable level, rejects short excursions and
// produces a clean registered level with one-cycle rise/fall strobes.
`timescale 1ns/1ps
module enable_synchronizer
  import enable_sync_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_in,
  output logic enable_out,
  output logic enable_rise,
  output logic enable_fall
);

  localparam int               CNT_W    = cnt_width(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("enable_synchronizer: SYNC_STAGES must be >= 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("enable_synchronizer: FILTER_LEN must be >= 1");
  end

  logic             w_s;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_rise;
  logic             r_fall;

  sync_cell #(
    .N_STAGES (SYNC_STAGES)
  ) u_sync_cell (
    .clk     (clk),
    .i_rst_n (reset),
    .i_d     (enable_in),
    .o_q     (w_s)
  );

  // Follow the synchronised level only after FILTER_LEN consecutive
  // disagreeing samples; strobe on the same edge that moves the level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_out) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_out  <= w_s;
        r_cnt  <= '0;
        r_rise <= w_s;
        r_fall <= ~w_s;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign enable_out  = r_out;
  assign enable_rise = r_rise;
  assign enable_fall = r_fall;

endmodule

// File: tb/tb_enable_synchronizer.sv
// Bench for enable_synchronizer: default instance (2 stages, filter 4) and a
// sweep instance (3 stages, filter 1) share clock, reset and enable_in.
`timescale 1ns/1ps
module tb_enable_synchronizer;

  logic clk = 1'b0;
  logic reset;
  logic enable_in;
  logic a_out, a_rise, a_fall;
  logic b_out, b_rise, b_fall;

  always #15.625 clk = ~clk;

  enable_synchronizer #(.SYNC_STAGES(2), .FILTER_LEN(4)) u_dut_a (
    .clk(clk), .reset(reset), .enable_in(enable_in),
    .enable_out(a_out), .enable_rise(a_rise), .enable_fall(a_fall)
  );

  enable_synchronizer #(.SYNC_STAGES(3), .FILTER_LEN(1)) u_dut_b (
    .clk(clk), .reset(reset), .enable_in(enable_in),
    .enable_out(b_out), .enable_rise(b_rise), .enable_fall(b_fall)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: the output takes a new value once the last FILTER_LEN
  // synchronised samples (since reset) all disagree with it; the synchronised
  // sample is simply enable_in as seen SYNC_STAGES edges earlier.
  int       ns_p[2] = '{2, 3};
  int       nf_p[2] = '{4, 1};
  bit [7:0] in_hist[2];
  bit [7:0] s_hist[2];
  int       s_cnt[2];
  bit       m_out[2], m_rise[2], m_fall[2];
  bit       mdl_s, mdl_diff;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset !== 1'b1) begin
        in_hist[d] = '0;
        s_hist[d]  = '0;
        s_cnt[d]   = 0;
        m_out[d]   = 1'b0;
        m_rise[d]  = 1'b0;
        m_fall[d]  = 1'b0;
      end else begin
        mdl_s      = in_hist[d][ns_p[d]-1];
        in_hist[d] = {in_hist[d][6:0], enable_in === 1'b1};
        s_hist[d]  = {s_hist[d][6:0], mdl_s};
        if (s_cnt[d] < 16) s_cnt[d]++;
        m_rise[d] = 1'b0;
        m_fall[d] = 1'b0;
        if (s_cnt[d] >= nf_p[d]) begin
          mdl_diff = 1'b1;
          for (int j = 0; j < nf_p[d]; j++)
            if (s_hist[d][j] == m_out[d]) mdl_diff = 1'b0;
          if (mdl_diff) begin
            m_out[d]  = mdl_s;
            m_rise[d] = mdl_s;
            m_fall[d] = ~mdl_s;
          end
        end
      end
    end
    #1;
    chk("mdl_a_out",  a_out,  m_out[0]);
    chk("mdl_a_rise", a_rise, m_rise[0]);
    chk("mdl_a_fall", a_fall, m_fall[0]);
    chk("mdl_b_out",  b_out,  m_out[1]);
    chk("mdl_b_rise", b_rise, m_rise[1]);
    chk("mdl_b_fall", b_fall, m_fall[1]);
  end

  // Drive inputs on the falling edge, return just after the rising edge.
  task automatic step(input logic r, input logic e);
    @(negedge clk);
    reset     = r;
    enable_in = e;
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic rst;
    logic en;
    logic o;
    logic ri;
    logic fa;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic en, input logic o,
                     input logic ri, input logic fa, input int n);
    vec_t v;
    v.rst = rst; v.en = en; v.o = o; v.ri = ri; v.fa = fa;
    repeat (n) tbl.push_back(v);
  endtask

  int rises, falls, highs, idx, len;
  logic en_hist[64];
  logic lvl;

  initial begin
    reset     = 1'b0;
    enable_in = 1'b0;

    // Expected values for the default instance, one record per clock edge.
    add(0, 1, 0, 0, 0, 5);  // reset held with enable high
    add(1, 1, 0, 0, 0, 5);  // release: five edges of latency
    add(1, 1, 1, 1, 0, 1);  // sixth non-reset edge rises
    add(1, 1, 1, 0, 0, 2);
    add(1, 0, 1, 0, 0, 5);  // falling edge latency
    add(1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 3);
    add(1, 1, 0, 0, 0, 3);  // 3-cycle glitch rejected
    add(1, 0, 0, 0, 0, 8);
    add(1, 1, 0, 0, 0, 4);  // 4-cycle pulse accepted
    add(1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 1, 0, 1);
    add(1, 0, 1, 0, 0, 3);
    add(1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 4);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en);
      chk($sformatf("tbl%0d_out", i),  a_out,  tbl[i].o);
      chk($sformatf("tbl%0d_rise", i), a_rise, tbl[i].ri);
      chk($sformatf("tbl%0d_fall", i), a_fall, tbl[i].fa);
    end

    // Level change: 50-cycle high pulse starting after 3000 ns.
    while ($time < 3000) step(1, 0);
    rises = 0; falls = 0; highs = 0; idx = -1;
    for (int k = 0; k < 65; k++) begin
      step(1, (k < 50) ? 1'b1 : 1'b0);
      if (a_rise) begin rises++; if (idx < 0) idx = k + 1; end
      if (a_fall) falls++;
      if (a_out) highs++;
    end
    chk_int("lvl_rise_count", rises, 1);
    chk_int("lvl_fall_count", falls, 1);
    chk_int("lvl_high_cycles", highs, 50);
    chk_int("lvl_rise_edge", idx, 6);

    // Reset two edges after the synchronised level goes high.
    repeat (10) step(1, 0);
    highs = 0;
    step(1, 1); highs += a_out;
    step(1, 1); highs += a_out;
    step(1, 1); highs += a_out;
    step(0, 1); highs += a_out;
    step(0, 1); highs += a_out;
    chk_int("midrst_out_high", highs, 0);
    idx = -1;
    for (int k = 0; k < 20 && idx < 0; k++) begin
      step(1, 1);
      if (a_rise) idx = k + 1;
      else if (a_out) highs++;
    end
    chk_int("midrst_rise_edge", idx, 6);
    chk_int("midrst_early_high", highs, 0);

    // Toggle every cycle: filtered output frozen, unfiltered one follows.
    repeat (8) step(1, 1);
    lvl = a_out;
    rises = 0;
    for (int k = 0; k < 40; k++) begin
      en_hist[k] = k[0] ? 1'b1 : 1'b0;
      step(1, en_hist[k]);
      if (a_rise || a_fall || a_out != lvl) rises++;
      if (k >= 3) chk($sformatf("tog_b_out%0d", k), b_out, en_hist[k-3]);
    end
    chk_int("tog_a_changes", rises, 0);

    // Randomised levels of random duration with occasional resets.
    for (int k = 0; k < 600; k++) begin
      lvl = $urandom_range(0, 1);
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 99) < 3) begin
        repeat ($urandom_range(1, 3)) step(0, lvl);
      end
      repeat (len) step(1, lvl);
    end
    repeat (12) step(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
